ucore_output_channel: RTL and testbench

- Transmit side of a ucore channel. Buffers tokens produced by the PE and sends each one to the NoC using valid/ready.
- Each token fans out to up to N_DEST consumers with eager-fork semantics: a token retires only when every enabled destination has accepted it.
- Sits between the PE result path and the NoC router ports. It is the mirror of the ucore input channel.

---
 rtl/ucore_pkg.sv | 15 +
 rtl/ucore_output_fork.sv | 42 ++++
 rtl/ucore_output_channel.sv | 102 ++++++++++
 tb/tb_ucore_output_channel.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ucore_pkg.sv
// Shared types and default configuration for the ucore channel blocks.
package ucore_pkg;

   localparam int unsigned UCORE_DATA_WIDTH    = 32;
   localparam int unsigned UCORE_N_DEST        = 4;
   localparam int unsigned UCORE_OUT_BUF_DEPTH = 2;

   typedef logic [UCORE_DATA_WIDTH-1:0] ucore_token_t;

   // Pointer width that still works for a single-entry buffer.
   function automatic int unsigned ucore_ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ucore_output_fork.sv
// Eager-fork tracker for the head token: per-destination valids, sent
// bookkeeping and the retire decision once every enabled destination accepted.
module ucore_output_fork
   import ucore_pkg::*;
#(
   parameter int unsigned N_DEST = UCORE_N_DEST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              head_valid,
   input  logic [N_DEST-1:0] head_mask,
   input  logic [N_DEST-1:0] noc_iready,
   output logic [N_DEST-1:0] noc_ovalid,
   output logic              retire
);

   logic [N_DEST-1:0] sent;
   logic [N_DEST-1:0] done;

   // Valids depend only on registered state; ready only feeds done/retire.
   always_comb begin
      noc_ovalid = '0;
      done       = sent;
      retire     = 1'b0;
      if (head_valid) begin
         noc_ovalid = head_mask & ~sent;
         done       = sent | (noc_ovalid & noc_iready);
         retire     = ((done & head_mask) == head_mask);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sent <= '0;
      end else if (retire) begin
         sent <= '0;
      end else if (head_valid) begin
         sent <= done;
      end
   end

endmodule

// File: rtl/ucore_output_channel.sv
// Transmit side of a ucore channel: circular token buffer feeding an eager fork.
// Optional stall counter port enabled by UCORE_OUTPUT_STALL_CNT_EN.
module ucore_output_channel
   import ucore_pkg::*;
#(
   parameter int unsigned DATA_WIDTH          = UCORE_DATA_WIDTH,
   parameter int unsigned N_DEST              = UCORE_N_DEST,
   parameter int unsigned OUTPUT_BUFFER_DEPTH = UCORE_OUT_BUF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pe_ivalid,
   input  logic [DATA_WIDTH-1:0] pe_in,
   input  logic [N_DEST-1:0]     pe_dest_mask,
   output logic                  pe_oready,
   output logic [N_DEST-1:0]     noc_ovalid,
   output logic [DATA_WIDTH-1:0] noc_out,
   input  logic [N_DEST-1:0]     noc_iready
`ifdef UCORE_OUTPUT_STALL_CNT_EN
   ,
   output logic [31:0]           out_stall_cnt
`endif
);

   localparam int unsigned DEPTH = OUTPUT_BUFFER_DEPTH;
   localparam int unsigned PTR_W = ucore_ptr_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [N_DEST-1:0]     mask_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;

   logic                  head_valid;
   logic                  push;
   logic                  retire;

   assign head_valid = (count != '0);
   assign pe_oready  = ~rst & (count != CNT_W'(DEPTH));
   assign push       = pe_ivalid & pe_oready;
   assign noc_out    = data_mem[rd_ptr];

   ucore_output_fork #(
      .N_DEST (N_DEST)
   ) u_fork (
      .clk        (clk),
      .rst        (rst),
      .head_valid (head_valid),
      .head_mask  (mask_mem[rd_ptr]),
      .noc_iready (noc_iready),
      .noc_ovalid (noc_ovalid),
      .retire     (retire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_mem[i] <= '0;
            mask_mem[i] <= '0;
         end
      end else if (push) begin
         data_mem[wr_ptr] <= pe_in;
         mask_mem[wr_ptr] <= pe_dest_mask;
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (retire) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (push && !retire) begin
            count <= count + CNT_W'(1);
         end else if (retire && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef UCORE_OUTPUT_STALL_CNT_EN
   logic stall;
   assign stall = head_valid && (noc_ovalid != '0) && !retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_stall_cnt <= '0;
      end else if (stall && (out_stall_cnt != '1)) begin
         out_stall_cnt <= out_stall_cnt + 32'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ucore_output_channel.sv
// Directed self-checking bench for ucore_output_channel (default 32b, 4 dest, depth 2).
module tb_ucore_output_channel;

   logic        clk;
   logic        rst;
   logic        pe_ivalid;
   logic [31:0] pe_in;
   logic [3:0]  pe_dest_mask;
   logic        pe_oready;
   logic [3:0]  noc_ovalid;
   logic [31:0] noc_out;
   logic [3:0]  noc_iready;
`ifdef UCORE_OUTPUT_STALL_CNT_EN
   logic [31:0] out_stall_cnt;
`endif

   int n_cmp;
   int n_bad;

   ucore_output_channel dut (
      .clk          (clk),
      .rst          (rst),
      .pe_ivalid    (pe_ivalid),
      .pe_in        (pe_in),
      .pe_dest_mask (pe_dest_mask),
      .pe_oready    (pe_oready),
      .noc_ovalid   (noc_ovalid),
      .noc_out      (noc_out),
      .noc_iready   (noc_iready)
`ifdef UCORE_OUTPUT_STALL_CNT_EN
      ,
      .out_stall_cnt(out_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      pe_ivalid = 1'b0;
      pe_in = '0;
      pe_dest_mask = '0;
      noc_iready = '0;
      #12;
      chk("rst_oready", 64'(pe_oready), 64'd0);
      chk("rst_ovalid", 64'(noc_ovalid), 64'd0);
      chk("rst_out", 64'(noc_out), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_oready", 64'(pe_oready), 64'd1);
      chk("post_rst_count", 64'(dut.count), 64'd0);
`ifdef UCORE_OUTPUT_STALL_CNT_EN
      chk("post_rst_stall", 64'(out_stall_cnt), 64'd0);
`endif

      // Single token, two destinations both ready.
      pe_ivalid = 1'b1; pe_in = 32'hA5; pe_dest_mask = 4'b0011; noc_iready = 4'b1111;
      tick();
      pe_ivalid = 1'b0;
      chk("a5_ovalid", 64'(noc_ovalid), 64'h3);
      chk("a5_out", 64'(noc_out), 64'hA5);
      tick();
      chk("a5_retired_ovalid", 64'(noc_ovalid), 64'h0);
      chk("a5_retired_count", 64'(dut.count), 64'd0);

      // Partial acceptance: dest0 early, dest2 late.
      pe_ivalid = 1'b1; pe_in = 32'h11; pe_dest_mask = 4'b0101; noc_iready = 4'b0001;
      tick();
      pe_ivalid = 1'b0;
      chk("f11_c1_ovalid", 64'(noc_ovalid), 64'h5);
      tick();
      chk("f11_c2_ovalid", 64'(noc_ovalid), 64'h4);
      chk("f11_c2_out", 64'(noc_out), 64'h11);
      tick();
      chk("f11_c3_ovalid", 64'(noc_ovalid), 64'h4);
      tick();
      chk("f11_c4_ovalid", 64'(noc_ovalid), 64'h4);
      noc_iready = 4'b0100;
      tick();
      chk("f11_done_ovalid", 64'(noc_ovalid), 64'h0);
      chk("f11_sent_clear", 64'(dut.u_fork.sent), 64'h0);
      chk("f11_count", 64'(dut.count), 64'd0);

      // Fill beyond depth with ready low; third push waits.
      noc_iready = 4'b0000;
      pe_ivalid = 1'b1; pe_in = 32'h21; pe_dest_mask = 4'b0001;
      tick();
      chk("fill1_oready", 64'(pe_oready), 64'd1);
      pe_in = 32'h22;
      tick();
      chk("fill2_oready", 64'(pe_oready), 64'd0);
      chk("fill2_out", 64'(noc_out), 64'h21);
      pe_in = 32'h23;
      tick();
      chk("fill3_blocked_oready", 64'(pe_oready), 64'd0);
      chk("fill3_blocked_out", 64'(noc_out), 64'h21);
      noc_iready = 4'b0001;
      tick();
      chk("drain1_out", 64'(noc_out), 64'h22);
      chk("drain1_oready", 64'(pe_oready), 64'd1);
      chk("drain1_count", 64'(dut.count), 64'd1);
      tick();
      pe_ivalid = 1'b0;
      chk("swap_out", 64'(noc_out), 64'h23);
      chk("swap_ovalid", 64'(noc_ovalid), 64'h1);
      chk("swap_count", 64'(dut.count), 64'd1);
      tick();
      chk("drain3_ovalid", 64'(noc_ovalid), 64'h0);
      chk("drain3_count", 64'(dut.count), 64'd0);

      // Zero mask token is dropped after one cycle at head.
      noc_iready = 4'b0000;
      pe_ivalid = 1'b1; pe_in = 32'h44; pe_dest_mask = 4'b0000;
      tick();
      pe_ivalid = 1'b0;
      chk("zmask_ovalid", 64'(noc_ovalid), 64'h0);
      chk("zmask_count_head", 64'(dut.count), 64'd1);
      tick();
      chk("zmask_count_gone", 64'(dut.count), 64'd0);

      // Asynchronous reset in the middle of a fork.
      pe_ivalid = 1'b1; pe_in = 32'h55; pe_dest_mask = 4'b0011;
      tick();
      pe_in = 32'h66;
      tick();
      pe_ivalid = 1'b0;
      noc_iready = 4'b0001;
      tick();
      noc_iready = 4'b0000;
      chk("mid_ovalid", 64'(noc_ovalid), 64'h2);
      chk("mid_count", 64'(dut.count), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ovalid", 64'(noc_ovalid), 64'h0);
      chk("arst_oready", 64'(pe_oready), 64'd0);
      chk("arst_out", 64'(noc_out), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("arst_rel_oready", 64'(pe_oready), 64'd1);
      chk("arst_rel_count", 64'(dut.count), 64'd0);
      chk("arst_rel_ovalid", 64'(noc_ovalid), 64'h0);

`ifdef UCORE_OUTPUT_STALL_CNT_EN
      // Stall counter: five blocked cycles, no count on retire.
      chk("stall_start", 64'(out_stall_cnt), 64'd0);
      pe_ivalid = 1'b1; pe_in = 32'h77; pe_dest_mask = 4'b0001;
      tick();
      pe_ivalid = 1'b0;
      chk("stall_enq", 64'(out_stall_cnt), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("stall_five", 64'(out_stall_cnt), 64'd5);
      noc_iready = 4'b0001;
      tick();
      chk("stall_retire", 64'(out_stall_cnt), 64'd5);
      chk("stall_count", 64'(dut.count), 64'd0);
      noc_iready = 4'b0000;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
